// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_pkg
// Description : Shared definitions for the WS2812 receive decoder: FSM state
//               encoding and default timing constants for a 200 MHz clock.
// Revision    : 1.0  initial release
// ============================================================================
package ws2812_pkg;

    // Receive FSM states
    typedef enum logic [1:0] {
        S_SYNC = 2'd0,   // waiting for a reset-length low gap
        S_LOW  = 2'd1,   // line low between bits / frames
        S_HIGH = 2'd2    // measuring a high pulse
    } ws2812_state_t;

    // Default timing in clk cycles at 200 MHz
    localparam int DEF_MIN_HIGH   = 20;     // 0.1 us
    localparam int DEF_BIT_THRESH = 120;    // 0.6 us
    localparam int DEF_MAX_HIGH   = 400;    // 2.0 us
    localparam int DEF_RESET_CYC  = 10000;  // 50 us
    localparam int DEF_CNT_W      = 14;

endpackage : ws2812_pkg
`default_nettype wire

// File: rtl/ws2812_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_rx_sync
// Description : Two-flop synchroniser for the asynchronous WS2812 line plus a
//               third flop for single-cycle rise/fall detection.
// Ports       : clk    - system clock
//               Rst_n  - synchronous active-low reset
//               din    - asynchronous line input
//               level  - synchronised line level (s2)
//               rise   - one-cycle pulse on 0->1 of level
//               fall   - one-cycle pulse on 1->0 of level
// Revision    : 1.0  initial release
// ============================================================================
module ws2812_rx_sync (
    input  logic clk,
    input  logic Rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;

endmodule : ws2812_rx_sync
`default_nettype wire

// File: rtl/ws2812_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ws2812_rx_decoder
// Description : Decodes a WS2812 NRZ one-wire stream into bytes (MSB first).
//               Reports decoded bytes, end-of-frame (long low gap) and timing
//               errors as single-cycle registered pulses.
// Ports       : clk, Rst_n (sync active-low), din (async line input)
//               data_out[7:0], data_valid, frame_end, bit_err
//               frame_bytes[5:0], err_cnt[7:0] (statistics)
// Config      : WS2812_RX_STATS_EN - when defined, builds the per-frame byte
//               counter and saturating error counter; otherwise both outputs
//               are tied to zero.
// Revision    : 1.0  initial release
// ============================================================================
module ws2812_rx_decoder
    import ws2812_pkg::*;
#(
    parameter int MIN_HIGH   = DEF_MIN_HIGH,
    parameter int BIT_THRESH = DEF_BIT_THRESH,
    parameter int MAX_HIGH   = DEF_MAX_HIGH,
    parameter int RESET_CYC  = DEF_RESET_CYC,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       Rst_n,
    input  logic       din,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_end,
    output logic       bit_err,
    output logic [5:0] frame_bytes,
    output logic [7:0] err_cnt
);

    // The timer restarts from 0 on the cycle after an edge, so when it reads
    // N-1 the line has held its level for N complete cycles. Thresholds are
    // therefore compared against PARAM-1.
    localparam logic [CNT_W-1:0] c_min_last    = CNT_W'(MIN_HIGH - 1);
    localparam logic [CNT_W-1:0] c_thresh_last = CNT_W'(BIT_THRESH - 1);
    localparam logic [CNT_W-1:0] c_max_last    = CNT_W'(MAX_HIGH - 1);
    localparam logic [CNT_W-1:0] c_reset_last  = CNT_W'(RESET_CYC - 1);
    localparam logic [CNT_W-1:0] c_reset_cyc   = CNT_W'(RESET_CYC);

    logic w_level, w_rise, w_fall;

    ws2812_rx_sync u_sync (
        .clk   (clk),
        .Rst_n (Rst_n),
        .din   (din),
        .level (w_level),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    ws2812_state_t    state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_end_q, frame_end_d;
    logic             bit_err_q, bit_err_d;
    logic             w_bit;

    // Decoded value of the pulse ending this cycle (valid on fall in S_HIGH)
    assign w_bit = (timer_q >= c_thresh_last);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_end_d  = 1'b0;
        bit_err_d    = 1'b0;

        if (w_rise || w_fall) begin
            timer_d = '0;
        end else if (timer_q == c_reset_cyc) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        case (state_q)
            S_SYNC: begin
                // Entry into S_LOW here is silent: no frame_end on resync
                if (!w_level && !w_fall && (timer_q >= c_reset_last)) begin
                    state_d = S_LOW;
                end
            end

            S_LOW: begin
                if (w_rise) begin
                    state_d = S_HIGH;
                end else if (timer_q == c_reset_last) begin
                    // Timer passes this value exactly once per gap, which
                    // makes frame_end a natural one-shot.
                    frame_end_d = 1'b1;
                    bit_err_d   = (bit_cnt_q != 3'd0);
                    bit_cnt_d   = 3'd0;
                end
            end

            S_HIGH: begin
                if (w_fall) begin
                    if (timer_q < c_min_last) begin
                        bit_err_d = 1'b1;
                        bit_cnt_d = 3'd0;
                        state_d   = S_SYNC;
                    end else begin
                        shift_d = {shift_q[6:0], w_bit};
                        state_d = S_LOW;
                        if (bit_cnt_q == 3'd7) begin
                            data_out_d   = {shift_q[6:0], w_bit};
                            data_valid_d = 1'b1;
                            bit_cnt_d    = 3'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end else if (timer_q == c_max_last) begin
                    // Stuck high: leaving S_HIGH guarantees a single error
                    bit_err_d = 1'b1;
                    bit_cnt_d = 3'd0;
                    state_d   = S_SYNC;
                end
            end

            default: begin
                state_d   = S_SYNC;
                bit_cnt_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            state_q      <= S_SYNC;
            timer_q      <= '0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            data_out_q   <= 8'd0;
            data_valid_q <= 1'b0;
            frame_end_q  <= 1'b0;
            bit_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_end_q  <= frame_end_d;
            bit_err_q    <= bit_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_end  = frame_end_q;
    assign bit_err    = bit_err_q;

`ifdef WS2812_RX_STATS_EN
    logic [5:0] byte_cnt_q, byte_cnt_d;
    logic [5:0] frame_bytes_q, frame_bytes_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        byte_cnt_d    = byte_cnt_q;
        frame_bytes_d = frame_bytes_q;
        err_cnt_d     = err_cnt_q;

        if (frame_end_d) begin
            frame_bytes_d = byte_cnt_q;
            byte_cnt_d    = 6'd0;
        end else if (state_d == S_SYNC && state_q != S_SYNC) begin
            // A resync abandons the frame; its bytes are not reported
            byte_cnt_d = 6'd0;
        end else if (data_valid_d && byte_cnt_q != 6'd63) begin
            byte_cnt_d = byte_cnt_q + 6'd1;
        end

        if (bit_err_d && err_cnt_q != 8'd255) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            byte_cnt_q    <= 6'd0;
            frame_bytes_q <= 6'd0;
            err_cnt_q     <= 8'd0;
        end else begin
            byte_cnt_q    <= byte_cnt_d;
            frame_bytes_q <= frame_bytes_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign frame_bytes = frame_bytes_q;
    assign err_cnt     = err_cnt_q;
`else
    assign frame_bytes = 6'd0;
    assign err_cnt     = 8'd0;
`endif

endmodule : ws2812_rx_decoder
`default_nettype wire

// File: tb/tb_ws2812_rx_decoder.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module      : tb_ws2812_rx_decoder
// Description : Directed self-checking bench for ws2812_rx_decoder. The
//               frame-reset gap is scaled down to 1000 cycles to keep run
//               time short; pulse timings use the 200 MHz defaults.
//               Honours WS2812_RX_STATS_EN for the statistics outputs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ws2812_rx_decoder;

    localparam int RESET_CYC = 1000;
    localparam int GAP       = 1200;
`ifdef WS2812_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       Rst_n;
    logic       din;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_end;
    logic       bit_err;
    logic [5:0] frame_bytes;
    logic [7:0] err_cnt;

    ws2812_rx_decoder #(
        .MIN_HIGH   (20),
        .BIT_THRESH (120),
        .MAX_HIGH   (400),
        .RESET_CYC  (RESET_CYC),
        .CNT_W      (14)
    ) dut (
        .clk         (clk),
        .Rst_n       (Rst_n),
        .din         (din),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_end   (frame_end),
        .bit_err     (bit_err),
        .frame_bytes (frame_bytes),
        .err_cnt     (err_cnt)
    );

    always #2.5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Event log gathered on the falling edge
    int         dv_cnt = 0, fe_cnt = 0, be_cnt = 0, fe_be = 0, dv_fe = 0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (data_valid) begin
            dv_cnt = dv_cnt + 1;
            rx_q.push_back(data_out);
            if (frame_end) dv_fe = dv_fe + 1;
        end
        if (frame_end) begin
            fe_cnt = fe_cnt + 1;
            if (bit_err) fe_be = fe_be + 1;
        end
        if (bit_err) be_cnt = be_cnt + 1;
    end

    int dv0, fe0, be0, feb0;

    task automatic snap();
        dv0 = dv_cnt; fe0 = fe_cnt; be0 = be_cnt; feb0 = fe_be;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int hi, input int lo);
        din = 1'b1; cyc(hi);
        din = 1'b0; cyc(lo);
    endtask

    task automatic send_bit(input bit b);
        if (b) pulse(160, 90);
        else   pulse(80, 170);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    initial begin
        logic [7:0] v;
        Rst_n = 1'b0;
        din   = 1'b0;
        cyc(4);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_data_valid", 32'(data_valid), 32'h0);
        chk("rst_frame_end", 32'(frame_end), 32'h0);
        chk("rst_bit_err", 32'(bit_err), 32'h0);
        chk("rst_frame_bytes", 32'(frame_bytes), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt), 32'h0);
        Rst_n = 1'b1;

        // ---- 1: single byte 0xA5, latency on last bit ----
        cyc(GAP);
        chk("t1_sync_no_fe", 32'(fe_cnt), 32'd0);
        v = 8'hA5;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        din = 1'b1; cyc(160);
        din = 1'b0; cyc(2);
        chk("t1_lat_edge2", 32'(data_valid), 32'h0);
        cyc(1);
        chk("t1_lat_edge3", 32'(data_valid), 32'h1);
        chk("t1_data", 32'(data_out), 32'hA5);
        cyc(1);
        chk("t1_pulse_width", 32'(data_valid), 32'h0);
        cyc(GAP);
        chk("t1_dv_cnt", 32'(dv_cnt), 32'd1);
        chk("t1_fe_cnt", 32'(fe_cnt), 32'd1);
        chk("t1_be_cnt", 32'(be_cnt), 32'd0);
        chk("t1_data_hold", 32'(data_out), 32'hA5);
        chk("t1_frame_bytes", 32'(frame_bytes), STATS ? 32'd1 : 32'd0);

        // ---- 2: three bytes in one frame ----
        snap();
        send_byte(8'hFF); send_byte(8'h00); send_byte(8'h3C);
        cyc(GAP);
        chk("t2_dv", 32'(dv_cnt - dv0), 32'd3);
        chk("t2_b0", 32'(rx_q[1]), 32'hFF);
        chk("t2_b1", 32'(rx_q[2]), 32'h00);
        chk("t2_b2", 32'(rx_q[3]), 32'h3C);
        chk("t2_fe", 32'(fe_cnt - fe0), 32'd1);
        chk("t2_be", 32'(be_cnt - be0), 32'd0);
        chk("t2_frame_bytes", 32'(frame_bytes), STATS ? 32'd3 : 32'd0);

        // ---- 3: 10-cycle glitch mid-byte ----
        snap();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        pulse(10, 170);
        send_byte(8'h55);
        chk("t3_be", 32'(be_cnt - be0), 32'd1);
        chk("t3_no_dv", 32'(dv_cnt - dv0), 32'd0);
        cyc(GAP);
        chk("t3_resync_no_fe", 32'(fe_cnt - fe0), 32'd0);
        send_byte(8'h96);
        cyc(GAP);
        chk("t3_recover_dv", 32'(dv_cnt - dv0), 32'd1);
        chk("t3_recover_data", 32'(rx_q[4]), 32'h96);
        chk("t3_recover_fe", 32'(fe_cnt - fe0), 32'd1);
        chk("t3_frame_bytes", 32'(frame_bytes), STATS ? 32'd1 : 32'd0);

        // ---- 4: partial byte (5 bits) then gap ----
        snap();
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        cyc(GAP);
        chk("t4_fe", 32'(fe_cnt - fe0), 32'd1);
        chk("t4_be", 32'(be_cnt - be0), 32'd1);
        chk("t4_fe_be_same", 32'(fe_be - feb0), 32'd1);
        chk("t4_no_dv", 32'(dv_cnt - dv0), 32'd0);
        chk("t4_frame_bytes", 32'(frame_bytes), 32'd0);
        send_byte(8'hC3);
        cyc(GAP);
        chk("t4_next_data", 32'(rx_q[5]), 32'hC3);
        chk("t4_next_dv", 32'(dv_cnt - dv0), 32'd1);

        // ---- 5: stuck high for 3 us ----
        snap();
        din = 1'b1;
        cyc(402);
        chk("t5_before_400", 32'(bit_err), 32'h0);
        cyc(1);
        chk("t5_at_400", 32'(bit_err), 32'h1);
        cyc(1);
        chk("t5_after_400", 32'(bit_err), 32'h0);
        cyc(600 - 404);
        din = 1'b0;
        cyc(GAP);
        chk("t5_be_once", 32'(be_cnt - be0), 32'd1);
        chk("t5_no_fe", 32'(fe_cnt - fe0), 32'd0);
        chk("t5_err_cnt", 32'(err_cnt), STATS ? 32'd3 : 32'd0);

        // ---- 6a: reset pulse after bit 4 ----
        snap();
        v = 8'hF0;
        for (int i = 7; i >= 4; i--) send_bit(v[i]);
        Rst_n = 1'b0;
        cyc(1);
        chk("t6_rst_data_out", 32'(data_out), 32'h0);
        chk("t6_rst_pulses", 32'({data_valid, frame_end, bit_err}), 32'h0);
        chk("t6_rst_err_cnt", 32'(err_cnt), 32'h0);
        chk("t6_rst_frame_bytes", 32'(frame_bytes), 32'h0);
        Rst_n = 1'b1;
        for (int i = 3; i >= 0; i--) send_bit(v[i]);
        send_byte(8'h81);
        chk("t6_ignored_dv", 32'(dv_cnt - dv0), 32'd0);
        chk("t6_ignored_be", 32'(be_cnt - be0), 32'd0);
        cyc(GAP);
        chk("t6_ignored_fe", 32'(fe_cnt - fe0), 32'd0);
        send_byte(8'h81);
        cyc(GAP);
        chk("t6_after_gap", 32'(rx_q[6]), 32'h81);

        // ---- 6b: threshold, 120 cycles -> 1, 119 cycles -> 0 ----
        v = 8'hAA;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) pulse(120, 130);
            else      pulse(119, 130);
        end
        cyc(GAP);
        chk("t6_thresh_dv", 32'(dv_cnt - dv0), 32'd2);
        chk("t6_thresh_data", 32'(rx_q[7]), 32'hAA);
        chk("t6_never_dv_fe", 32'(dv_fe), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ws2812_rx_decoder
`default_nettype wire
